// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the ES1 SPU operator response checkers:
// checker state encoding and the saturating counter increment.
package elixirchip_es1_spu_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    CHECK  = 2'd1,
    FAIL   = 2'd2
  } checker_state_t;

  // Increment that sticks at the all-ones value of a 'bits'-wide counter (bits <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned bits);
    logic [63:0] max_v;
    if (bits >= 64) max_v = '1;
    else            max_v = (64'd1 << bits) - 64'd1;
    if (value >= max_v) return max_v;
    return value + 64'd1;
  endfunction

endpackage

// File: rtl/elixirchip_es1_spu_model_xor.sv
// Golden model of the XOR operator: clear/valid/hold first stage followed by a
// cke-gated shift out to LATENCY stages.
module elixirchip_es1_spu_model_xor
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int  LATENCY    = 1,
  parameter type data_t     = logic [7:0],
  parameter data_t CLEAR_DATA = '1
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  cke,
  input  data_t s_data0,
  input  data_t s_data1,
  input  logic  s_clear,
  input  logic  s_valid,
  output data_t exp_data
);

  data_t stage_q [LATENCY];
  data_t stage1_d;

  always_comb begin
    stage1_d = stage_q[0];
    if (s_clear)      stage1_d = CLEAR_DATA;
    else if (s_valid) stage1_d = s_data0 ^ s_data1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else if (cke) begin
      stage_q[0] <= stage1_d;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign exp_data = stage_q[LATENCY-1];

endmodule

// File: rtl/elixirchip_es1_spu_op_xor_checker.sv
// Response checker for the XOR operator: runs the golden model beside the operator,
// compares every enabled cycle after warm-up, counts results and captures the first mismatch.
module elixirchip_es1_spu_op_xor_checker
  import elixirchip_es1_spu_pkg::*;
#(
  parameter int    LATENCY    = 1,
  parameter int    DATA_BITS  = 8,
  parameter type   data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '1,
  parameter int    COUNT_BITS = 32,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  data_t                 s_data0,
  input  data_t                 s_data1,
  input  logic                  s_clear,
  input  logic                  s_valid,
  input  data_t                 m_data,
  input  logic                  check_en,
  output logic                  checking,
  output logic                  error,
  output logic [COUNT_BITS-1:0] cycle_count,
  output logic [COUNT_BITS-1:0] match_count,
  output logic [COUNT_BITS-1:0] err_count,
  output logic [COUNT_BITS-1:0] first_err_cycle,
  output data_t                 first_err_exp,
  output data_t                 first_err_act
);

  localparam int WARM_BITS = $clog2(LATENCY + 1);

  function automatic logic [COUNT_BITS-1:0] inc_sat(input logic [COUNT_BITS-1:0] v);
    return COUNT_BITS'(sat_inc(64'(v), COUNT_BITS));
  endfunction

  data_t exp_data;

  elixirchip_es1_spu_model_xor #(
    .LATENCY    (LATENCY),
    .data_t     (data_t),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_model (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .s_data0  (s_data0),
    .s_data1  (s_data1),
    .s_clear  (s_clear),
    .s_valid  (s_valid),
    .exp_data (exp_data)
  );

  checker_state_t        state_q, state_d;
  logic [WARM_BITS-1:0]  warm_q, warm_d;
  logic [COUNT_BITS-1:0] cycle_q, cycle_d;
  logic [COUNT_BITS-1:0] match_q, match_d;
  logic [COUNT_BITS-1:0] err_q, err_d;
  logic [COUNT_BITS-1:0] ferr_cycle_q, ferr_cycle_d;
  data_t                 ferr_exp_q, ferr_exp_d;
  data_t                 ferr_act_q, ferr_act_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WARMUP;
      warm_q       <= '0;
      cycle_q      <= '0;
      match_q      <= '0;
      err_q        <= '0;
      ferr_cycle_q <= '0;
      ferr_exp_q   <= '0;
      ferr_act_q   <= '0;
    end else begin
      state_q      <= state_d;
      warm_q       <= warm_d;
      cycle_q      <= cycle_d;
      match_q      <= match_d;
      err_q        <= err_d;
      ferr_cycle_q <= ferr_cycle_d;
      ferr_exp_q   <= ferr_exp_d;
      ferr_act_q   <= ferr_act_d;
    end
  end

  // Next state and counters; nothing moves without cke.
  always_comb begin
    state_d      = state_q;
    warm_d       = warm_q;
    cycle_d      = cycle_q;
    match_d      = match_q;
    err_d        = err_q;
    ferr_cycle_d = ferr_cycle_q;
    ferr_exp_d   = ferr_exp_q;
    ferr_act_d   = ferr_act_q;
    if (cke) begin
      cycle_d = inc_sat(cycle_q);
      unique case (state_q)
        WARMUP: begin
          warm_d = warm_q + 1'b1;
          if (int'(warm_q) + 1 >= LATENCY) state_d = CHECK;
        end
        CHECK, FAIL: begin
          if (check_en) begin
            if (exp_data == m_data) begin
              match_d = inc_sat(match_q);
            end else begin
              err_d = inc_sat(err_q);
              // Only the first mismatch is captured; FAIL freezes the record.
              if (state_q == CHECK) begin
                ferr_cycle_d = cycle_q;
                ferr_exp_d   = exp_data;
                ferr_act_d   = m_data;
                state_d      = FAIL;
              end
            end
          end
        end
        default: state_d = WARMUP;
      endcase
    end
  end

  always_comb begin
    checking        = (state_q == CHECK) || (state_q == FAIL);
    error           = (state_q == FAIL);
    cycle_count     = cycle_q;
    match_count     = match_q;
    err_count       = err_q;
    first_err_cycle = ferr_cycle_q;
    first_err_exp   = ferr_exp_q;
    first_err_act   = ferr_act_q;
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_xor_checker.sv
// Directed bench for the XOR response checker: four checker instances (latency 1, 3, 4
// and a 4-bit-counter variant) share one stimulus stream beside a reference operator.
module tb_elixirchip_es1_spu_op_xor_checker;

  logic       clk = 1'b0;
  logic       reset, cke, s_clear, s_valid, check_en;
  logic [7:0] s_data0, s_data1;

  // Reference operator: same behaviour as the real op, taps at latency 1..4.
  logic [7:0] ref_p [1:4];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= 4; k++) ref_p[k] <= 8'h00;
    end else if (cke) begin
      ref_p[1] <= s_clear ? 8'hFF : (s_valid ? (s_data0 ^ s_data1) : ref_p[1]);
      for (int k = 2; k <= 4; k++) ref_p[k] <= ref_p[k-1];
    end
  end

  logic       force1_en, force_s_en;
  logic [7:0] force1_val;
  logic [7:0] m_data1, m_data3, m_data4, m_data_s;
  assign m_data1  = force1_en ? force1_val : ref_p[1];
  assign m_data3  = ref_p[3];
  assign m_data4  = ref_p[4];
  assign m_data_s = force_s_en ? ~ref_p[1] : ref_p[1];

  // Outputs of the 32-bit-counter instances: index 0 = L1, 1 = L3, 2 = L4.
  logic        chk_w [3];
  logic        err_w [3];
  logic [31:0] cyc_w [3];
  logic [31:0] mat_w [3];
  logic [31:0] ecnt_w [3];
  logic [31:0] fcyc_w [3];
  logic [7:0]  fexp_w [3];
  logic [7:0]  fact_w [3];
  logic [7:0]  m_w [3];
  assign m_w[0] = m_data1;
  assign m_w[1] = m_data3;
  assign m_w[2] = m_data4;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : 4;
    elixirchip_es1_spu_op_xor_checker #(
      .LATENCY(LAT), .DATA_BITS(8), .COUNT_BITS(32)
    ) u_dut (
      .clk(clk), .reset(reset), .cke(cke),
      .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
      .m_data(m_w[gi]), .check_en(check_en),
      .checking(chk_w[gi]), .error(err_w[gi]),
      .cycle_count(cyc_w[gi]), .match_count(mat_w[gi]), .err_count(ecnt_w[gi]),
      .first_err_cycle(fcyc_w[gi]), .first_err_exp(fexp_w[gi]), .first_err_act(fact_w[gi])
    );
  end

  logic       s_chk, s_err;
  logic [3:0] s_cyc, s_mat, s_ecnt, s_fcyc;
  logic [7:0] s_fexp, s_fact;

  elixirchip_es1_spu_op_xor_checker #(
    .LATENCY(1), .DATA_BITS(8), .COUNT_BITS(4)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .cke(cke),
    .s_data0(s_data0), .s_data1(s_data1), .s_clear(s_clear), .s_valid(s_valid),
    .m_data(m_data_s), .check_en(check_en),
    .checking(s_chk), .error(s_err),
    .cycle_count(s_cyc), .match_count(s_mat), .err_count(s_ecnt),
    .first_err_cycle(s_fcyc), .first_err_exp(s_fexp), .first_err_act(s_fact)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hi_edges;

  initial begin
    reset = 1'b1; cke = 1'b1; check_en = 1'b1;
    s_clear = 1'b0; s_valid = 1'b0; s_data0 = 8'h00; s_data1 = 8'h00;
    force1_en = 1'b0; force1_val = 8'h00; force_s_en = 1'b0;
    step(2);
    reset = 1'b0;
    s_valid = 1'b1; s_data0 = 8'h5A; s_data1 = 8'hFF;

    // Reset state
    check_value("rst_checking", 32'(chk_w[1]), 32'd0);
    check_value("rst_error", 32'(err_w[1]), 32'd0);
    check_value("rst_cycle", cyc_w[1], 32'd0);
    check_value("rst_match", mat_w[1], 32'd0);
    check_value("rst_errcnt", ecnt_w[1], 32'd0);
    check_value("rst_fcycle", fcyc_w[1], 32'd0);
    check_value("rst_fexp", 32'(fexp_w[1]), 32'd0);
    check_value("rst_fact", 32'(fact_w[1]), 32'd0);

    // Warm-up, LATENCY=3
    step(1);
    check_value("wu_l3_cycle_e1", cyc_w[1], 32'd1);
    check_value("wu_l3_checking_e1", 32'(chk_w[1]), 32'd0);
    step(1);
    check_value("wu_l3_checking_e2", 32'(chk_w[1]), 32'd0);
    step(1);
    check_value("wu_l3_checking_e3", 32'(chk_w[1]), 32'd1);
    check_value("wu_l3_match_e3", mat_w[1], 32'd0);
    step(1);
    check_value("wu_l3_match_e4", mat_w[1], 32'd1);

    // Clean run, LATENCY=1
    check_value("clean_l1_match_e4", mat_w[0], 32'd3);
    step(5);
    check_value("clean_l1_match_e9", mat_w[0], 32'd8);
    check_value("clean_l1_cycle_e9", cyc_w[0], 32'd9);
    check_value("clean_l1_error", 32'(err_w[0]), 32'd0);

    // Clear has priority over valid; then inject 0x00 against expected 0xFF
    s_clear = 1'b1;
    step(1);
    force1_en = 1'b1; force1_val = 8'h00; s_clear = 1'b0; s_valid = 1'b0;
    step(1);
    check_value("clr_error", 32'(err_w[0]), 32'd1);
    check_value("clr_errcnt", ecnt_w[0], 32'd1);
    check_value("clr_fexp", 32'(fexp_w[0]), 32'hFF);
    check_value("clr_fact", 32'(fact_w[0]), 32'h00);
    check_value("clr_fcycle", fcyc_w[0], 32'd10);
    check_value("clr_match", mat_w[0], 32'd9);

    // Mid-run reset clears the capture registers
    reset = 1'b1; force1_en = 1'b0;
    step(1);
    check_value("rst2_error", 32'(err_w[0]), 32'd0);
    check_value("rst2_errcnt", ecnt_w[0], 32'd0);
    check_value("rst2_fexp", 32'(fexp_w[0]), 32'd0);
    check_value("rst2_fcycle", fcyc_w[0], 32'd0);
    reset = 1'b0; s_valid = 1'b1; s_data0 = 8'h5A; s_data1 = 8'hFF;

    // Hold on s_valid=0: expected stays 0xA5
    step(1);
    s_valid = 1'b0;
    step(2);
    check_value("hold_match", mat_w[0], 32'd2);
    force1_en = 1'b1; force1_val = 8'hA4;
    step(1);
    check_value("hold_errcnt1", ecnt_w[0], 32'd1);
    check_value("hold_fexp", 32'(fexp_w[0]), 32'hA5);
    check_value("hold_fact", 32'(fact_w[0]), 32'hA4);
    check_value("hold_fcycle", fcyc_w[0], 32'd3);
    force1_en = 1'b0;
    step(2);
    check_value("hold_match_fail", mat_w[0], 32'd4);
    force1_en = 1'b1; force1_val = 8'h00;
    step(1);
    check_value("hold_errcnt2", ecnt_w[0], 32'd2);
    check_value("hold_fact_frozen", 32'(fact_w[0]), 32'hA4);
    check_value("hold_fcycle_frozen", fcyc_w[0], 32'd3);

    // check_en low in FAIL: counters pause, state held
    check_en = 1'b0;
    step(2);
    check_value("pause_errcnt", ecnt_w[0], 32'd2);
    check_value("pause_match", mat_w[0], 32'd4);
    check_value("pause_checking", 32'(chk_w[0]), 32'd1);
    check_value("pause_error", 32'(err_w[0]), 32'd1);
    check_value("pause_cycle", cyc_w[0], 32'd9);
    check_en = 1'b1; force1_en = 1'b0;

    // Saturation with 4-bit counters
    reset = 1'b1;
    step(1);
    reset = 1'b0; s_valid = 1'b1; s_data0 = 8'h5A; s_data1 = 8'hFF;
    step(20);
    check_value("sat_match", 32'(s_mat), 32'd15);
    check_value("sat_cycle", 32'(s_cyc), 32'd15);
    force_s_en = 1'b1;
    step(17);
    check_value("sat_errcnt", 32'(s_ecnt), 32'd15);
    check_value("sat_error", 32'(s_err), 32'd1);
    check_value("sat_match_held", 32'(s_mat), 32'd15);
    check_value("sat_fexp", 32'(s_fexp), 32'hA5);
    check_value("sat_fact", 32'(s_fact), 32'h5A);
    check_value("sat_fcycle", 32'(s_fcyc), 32'd15);
    reset = 1'b1;
    step(1);
    check_value("sat_rst_checking", 32'(s_chk), 32'd0);
    check_value("sat_rst_error", 32'(s_err), 32'd0);
    check_value("sat_rst_cycle", 32'(s_cyc), 32'd0);
    check_value("sat_rst_match", 32'(s_mat), 32'd0);
    check_value("sat_rst_errcnt", 32'(s_ecnt), 32'd0);
    check_value("sat_rst_fexp", 32'(s_fexp), 32'd0);
    check_value("sat_rst_fact", 32'(s_fact), 32'd0);
    check_value("sat_rst_fcycle", 32'(s_fcyc), 32'd0);
    reset = 1'b0; force_s_en = 1'b0;

    // Random cke (about 90 % high), LATENCY=4, correct operator
    hi_edges = 0;
    for (int i = 0; i < 1000; i++) begin
      cke     = ($urandom_range(0, 9) != 0);
      s_valid = ($urandom_range(0, 9) < 7);
      s_clear = ($urandom_range(0, 19) == 0);
      s_data0 = 8'($urandom_range(0, 255));
      s_data1 = 8'($urandom_range(0, 255));
      if (cke) hi_edges++;
      step(1);
    end
    check_value("rnd_cycle", cyc_w[2], 32'(hi_edges));
    check_value("rnd_errcnt", ecnt_w[2], 32'd0);
    check_value("rnd_match", mat_w[2], 32'(hi_edges - 4));
    check_value("rnd_error", 32'(err_w[2]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
